// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter_if
//  Purpose  : Bundle of writeback, long-latency, query and register-file
//             write-port signals around regfile_write_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) ();
    localparam int c_CW = $clog2(DEPTH + 1);

    logic            pipe_we;
    logic [AW-1:0]   pipe_rd;
    logic [DW-1:0]   pipe_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [AW-1:0]   lu_rd;
    logic [DW-1:0]   lu_data;
    logic [AW-1:0]   q_reg;
    logic            q_pending;
    logic [c_CW-1:0] fifo_count;
    logic            RegWrite;
    logic [AW-1:0]   R_W;
    logic [DW-1:0]   W;

    modport master (
        input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, q_reg,
        output lu_ready, q_pending, fifo_count, RegWrite, R_W, W
    );

    modport slave (
        output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, q_reg,
        input  lu_ready, q_pending, fifo_count, RegWrite, R_W, W
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Merges pipeline writeback with FIFO-buffered long-latency
//             results onto the single register-file write port.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  wire logic              CLK,
    input  wire logic              Reset,
    regfile_write_arbiter_if.master bus
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic            r_live [DEPTH];
    logic [AW-1:0]   r_rd   [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_we;
    logic [AW-1:0]   r_rw;
    logic [DW-1:0]   r_w;

    logic w_full;
    logic w_empty;
    logic w_ready;
    logic w_push;
    logic w_pipe_wr;
    logic w_pop;
    logic w_pend;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_ready   = !w_full && !Reset;
    // Offers to r0 are accepted so the unit can retire, but never stored.
    assign w_push    = bus.lu_valid && w_ready && (bus.lu_rd != '0);
    assign w_pipe_wr = bus.pipe_we && (bus.pipe_rd != '0);
    assign w_pop     = !w_pipe_wr && !w_empty;

    // Live bits are cleared on pop, so a set live bit always marks a stored entry.
    always_comb begin
        w_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_rd[i] == bus.q_reg)) w_pend = 1'b1;
        end
        if (bus.q_reg == '0) w_pend = 1'b0;
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wptr == i[c_PW-1:0])) begin
                r_rd[i]   <= bus.lu_rd;
                r_data[i] <= bus.lu_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_rw    <= '0;
            r_w     <= '0;
            for (int i = 0; i < DEPTH; i++) r_live[i] <= 1'b0;
        end else begin
            // The push assignment comes last: a same-edge push is younger than the kill.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && (r_rptr == i[c_PW-1:0])) r_live[i] <= 1'b0;
                if (w_pipe_wr && (r_rd[i] == bus.pipe_rd)) r_live[i] <= 1'b0;
                if (w_push && (r_wptr == i[c_PW-1:0])) r_live[i] <= 1'b1;
            end

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);

            if (w_pipe_wr) begin
                r_we <= 1'b1;
                r_rw <= bus.pipe_rd;
                r_w  <= bus.pipe_data;
            end else if (!w_empty && r_live[r_rptr]) begin
                r_we <= 1'b1;
                r_rw <= r_rd[r_rptr];
                r_w  <= r_data[r_rptr];
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.lu_ready   = w_ready;
    assign bus.q_pending  = w_pend;
    assign bus.fifo_count = r_count;
    assign bus.RegWrite   = r_we;
    assign bus.R_W        = r_rw;
    assign bus.W          = r_w;
endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_arbiter
//  Purpose  : Directed self-checking bench for regfile_write_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;
    localparam int c_DEPTH = 4;
    localparam int c_DW    = 32;
    localparam int c_AW    = 5;

    logic CLK = 1'b0;
    logic Reset;
    int   r_vec_count  = 0;
    int   r_miss_count = 0;

    regfile_write_arbiter_if #(.DEPTH(c_DEPTH), .DW(c_DW), .AW(c_AW)) bus ();

    regfile_write_arbiter #(.DEPTH(c_DEPTH), .DW(c_DW), .AW(c_AW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_vec_count++;
        if (got !== exp) begin
            r_miss_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_we   = 1'b0;
        bus.pipe_rd   = '0;
        bus.pipe_data = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_data   = '0;
    endtask

    initial begin
        idle_inputs();
        bus.q_reg = '0;
        Reset     = 1'b1;

        // Reset then idle
        tick();
        tick();
        chk("rst_we",    64'(bus.RegWrite),   64'd0);
        chk("rst_rw",    64'(bus.R_W),        64'd0);
        chk("rst_w",     64'(bus.W),          64'd0);
        chk("rst_cnt",   64'(bus.fifo_count), 64'd0);
        chk("rst_ready", 64'(bus.lu_ready),   64'd0);
        Reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.lu_ready), 64'd1);

        // Pipeline write, then hold, then write to r0
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
        tick();
        chk("pipe_we",   64'(bus.RegWrite), 64'd1);
        chk("pipe_rw",   64'(bus.R_W),      64'd5);
        chk("pipe_w",    64'(bus.W),        64'hDEADBEEF);
        idle_inputs();
        tick();
        chk("pipe_off",  64'(bus.RegWrite), 64'd0);
        chk("pipe_hold", 64'(bus.R_W),      64'd5);
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'h123;
        tick();
        chk("r0_we",     64'(bus.RegWrite), 64'd0);
        chk("r0_hold_w", 64'(bus.W),        64'hDEADBEEF);
        idle_inputs();

        // Fill under contention, ignored 5th offer, in-order drain
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_data = 32'h99;
        for (int k = 1; k <= 4; k++) begin
            bus.lu_valid = 1'b1; bus.lu_rd = 5'(k); bus.lu_data = 32'(k * 'h11);
            tick();
            chk("fill_rw",  64'(bus.R_W),        64'd9);
            chk("fill_cnt", 64'(bus.fifo_count), 64'(k));
        end
        chk("full_ready", 64'(bus.lu_ready), 64'd0);
        bus.lu_rd = 5'd5; bus.lu_data = 32'h55;
        tick();
        chk("full_cnt", 64'(bus.fifo_count), 64'd4);
        chk("full_we",  64'(bus.RegWrite),   64'd1);
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_we", 64'(bus.RegWrite), 64'd1);
            chk("drain_rw", 64'(bus.R_W),      64'(k));
            chk("drain_w",  64'(bus.W),        64'(k * 'h11));
        end
        chk("drain_cnt",   64'(bus.fifo_count), 64'd0);
        chk("drain_ready", 64'(bus.lu_ready),   64'd1);
        tick();
        chk("drain_idle",  64'(bus.RegWrite),   64'd0);

        // Kill of an older long-latency result
        bus.q_reg = 5'd7;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'hAAAA;
        tick();
        chk("kill_push_cnt", 64'(bus.fifo_count), 64'd1);
        chk("kill_push_we",  64'(bus.RegWrite),   64'd0);
        idle_inputs();
        #1;
        chk("kill_pend_pre", 64'(bus.q_pending), 64'd1);
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_data = 32'hBBBB;
        tick();
        chk("kill_we",   64'(bus.RegWrite),   64'd1);
        chk("kill_w",    64'(bus.W),          64'hBBBB);
        chk("kill_cnt",  64'(bus.fifo_count), 64'd1);
        chk("kill_pend", 64'(bus.q_pending),  64'd0);
        idle_inputs();
        tick();
        chk("kill_pop_we",  64'(bus.RegWrite),   64'd0);
        chk("kill_pop_cnt", 64'(bus.fifo_count), 64'd0);
        chk("kill_pop_w",   64'(bus.W),          64'hBBBB);

        // Simultaneous push and pipeline write to the same register
        bus.q_reg = 5'd3;
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h1;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 32'h2;
        tick();
        chk("sim_w1",   64'(bus.W),         64'h1);
        chk("sim_pend", 64'(bus.q_pending), 64'd1);
        idle_inputs();
        tick();
        chk("sim_we2",   64'(bus.RegWrite),  64'd1);
        chk("sim_w2",    64'(bus.W),         64'h2);
        chk("sim_pend2", 64'(bus.q_pending), 64'd0);

        // Pointer wrap with one push and one pop per cycle
        for (int i = 0; i <= 10; i++) begin
            bus.lu_valid = (i < 10);
            bus.lu_rd    = 5'(i + 1);
            bus.lu_data  = 32'('h100 + i);
            tick();
            if (i >= 1) begin
                chk("wrap_rw", 64'(bus.R_W), 64'(i));
                chk("wrap_w",  64'(bus.W),   64'('h100 + i - 1));
            end
            chk("wrap_cnt", 64'(bus.fifo_count), (i < 10) ? 64'd1 : 64'd0);
        end
        idle_inputs();

        // Reset with three stored entries
        bus.q_reg = 5'd10;
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_data = 32'h9;
        for (int k = 0; k < 3; k++) begin
            bus.lu_valid = 1'b1; bus.lu_rd = 5'(10 + k); bus.lu_data = 32'(k);
            tick();
        end
        chk("mid_cnt",  64'(bus.fifo_count), 64'd3);
        chk("mid_pend", 64'(bus.q_pending),  64'd1);
        idle_inputs();
        Reset = 1'b1;
        tick();
        chk("mid_rst_cnt",   64'(bus.fifo_count), 64'd0);
        chk("mid_rst_we",    64'(bus.RegWrite),   64'd0);
        chk("mid_rst_ready", 64'(bus.lu_ready),   64'd0);
        chk("mid_rst_pend",  64'(bus.q_pending),  64'd0);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("after_rst_we", 64'(bus.RegWrite), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", r_vec_count, r_miss_count);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-side master for the CPU register file. Merges single-cycle writeback from the main pipeline with results from long-latency units (multiply/divide) into the register file's single write port (RegWrite, R_W, W). Long-latency results are held in a small FIFO and drained in idle write slots. The block also provides a pending-write query so the hazard logic can stall readers of not-yet-written registers.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries; power of two, 2..16
- DW, 32, data width
- AW, 5, register index width

Ports:
- CLK  in  1  clock
- Reset  in  1  synchronous, active-high
- pipe_we  in  1  main-pipeline writeback request this cycle
- pipe_rd  in  AW  pipeline destination register
- pipe_data  in  DW  pipeline write data
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept; equals !full && !Reset
- lu_rd  in  AW  long-latency destination register
- lu_data  in  DW  long-latency result
- q_reg  in  AW  register index to query
- q_pending  out  1  a live FIFO entry targets q_reg (combinational)
- fifo_count  out  clog2(DEPTH+1)  stored entries, live and killed
- RegWrite  out  1  register-file write enable (registered)
- R_W  out  AW  register-file write index (registered)
- W  out  DW  register-file write data (registered)

## Operation
- FIFO entry: {live, rd, data}. Circular buffer with read/write pointers that wrap modulo DEPTH, plus a count.
- Push rule: when lu_valid && lu_ready && lu_rd != 0, push {1, lu_rd, lu_data}.
  - lu_valid && lu_ready && lu_rd == 0 is accepted and discarded; nothing is pushed.
- Output select, evaluated each clock edge, first match wins:
  1. pipe_we && pipe_rd != 0: RegWrite<=1, R_W<=pipe_rd, W<=pipe_data. FIFO is not popped.
  2. FIFO not empty and head live: RegWrite<=1, R_W<=head.rd, W<=head.data, then pop.
  3. FIFO not empty and head killed: RegWrite<=0, then pop silently.
  4. Otherwise RegWrite<=0. R_W and W hold their previous values.
- pipe_we with pipe_rd == 0 causes no write and no kill. That slot counts as idle and may drain the FIFO.
- Kill rule: when pipe_we && pipe_rd != 0, every stored entry with rd == pipe_rd has live cleared at the same edge. This prevents an older long-latency result from overwriting a newer pipeline value.
  - An entry being pushed at the same edge is not killed; it is treated as younger than the pipeline write.
- Push and pop at the same edge are allowed. Count is unchanged; both pointers advance.
- Full: lu_ready=0. lu_valid is ignored, with no bypass even if a pop occurs that cycle.
- q_pending = (q_reg != 0) && any live stored entry has rd == q_reg. Killed entries and the entry being offered on lu_* do not count.
- Reset: FIFO emptied and all live bits cleared, count=0, RegWrite=0, R_W=0, W=0, lu_ready=0 while Reset is high.
  - Reset asserted mid-drain discards all entries. No write is issued in the cycle after reset.

## Timing
- Pipeline write: pipe_we in cycle t produces RegWrite=1 during cycle t+1.
- Long-latency write, best case: accepted at the edge ending cycle t, stored during t+1, popped at the edge ending t+1, RegWrite=1 during t+2.
- Each cycle with pipe_we && pipe_rd != 0 delays the FIFO drain by one cycle. There is no starvation guarantee beyond pipeline idle slots.
- lu_ready, q_pending and fifo_count reflect state after the most recent edge. q_pending and lu_ready are combinational from state and inputs.
- The register-file write lands at the edge ending the cycle in which RegWrite=1. Data written is therefore readable two edges after pipe_we and three edges after long-latency acceptance.

## Test plan
- Reset then idle: Reset=1 for 2 cycles -> RegWrite=0, R_W=0, W=0, fifo_count=0, lu_ready=0 during Reset and 1 after.
- Pipeline write: pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF in cycle 0 -> in cycle 1 RegWrite=1, R_W=5, W=0xDEADBEEF; in cycle 2 RegWrite=0. pipe_rd=0 -> no write.
- FIFO fill and drain under contention: push lu_rd=1..4 (data 0x11..0x44) on 4 consecutive cycles while pipe_we=1 to rd=9 -> lu_ready=0 and fifo_count=4 after the 4th push, a 5th offer is ignored. Drop pipe_we -> writes to r1..r4 in order on 4 consecutive cycles, then lu_ready=1.
- Kill: push lu_rd=7 data 0xAAAA, then pipe_we rd=7 data 0xBBBB before the drain -> single write r7=0xBBBB, the killed entry pops with RegWrite=0, q_pending(q_reg=7)=0 after the kill.
- Simultaneous push and kill: same cycle pipe_we rd=3 data 0x1 and lu push rd=3 data 0x2 -> r3=0x1 written first, then r3=0x2. q_pending(3)=1 until the pop.
- Pointer wrap and reset: 10 push/pop cycles with DEPTH=4 -> in-order data and no loss. Reset with 3 entries stored -> count=0, no further RegWrite.
